joy_db15_tx: RTL
================

// Module: joy_db15_tx
// PURPOSE
//  Responder end of the DB15 serial joystick link: emulates the adapter's parallel-in/serial-out chain.
//  Samples the receiver's JOY_LOAD / JOY_CLK strobes and drives JOY_DATA with two players' buttons.
//  Drives USER_IN[5] for loop-back verification of the DB15 receiver and for FPGA-to-FPGA controller bridging.
// PARAMETERS
//  PLAYER_BITS  16        buttons per player; frame length FRAME = 2*PLAYER_BITS
//  SYNC_STAGES  2         synchroniser depth on joy_clk / joy_load (>=2)
//  IDLE_CYCLES  4800000   clk_sys cycles without a load strobe before link_idle asserts (100 ms @ 48 MHz)
// PORTS
//  clk_sys     in   1   system clock, 48 MHz
//  reset_n     in   1   asynchronous, active-low reset
//  joystick1   in   16  player-1 buttons, active-high; bit order RLDU,B,C,A,X,Y,Z,S,M,...
//  joystick2   in   16  player-2 buttons, active-high
//  joy_load    in   1   receiver load strobe, active-low, asynchronous to clk_sys
//  joy_clk     in   1   receiver shift clock, shifts on rising edge, asynchronous to clk_sys
//  joy_data    out  1   serial data, active-low (0 = pressed)
//  frame_done  out  1   one-cycle pulse when the FRAME-th shift edge is consumed
//  overrun     out  1   sticky; set when a shift edge arrives after the frame is exhausted; cleared by next load
//  link_idle   out  1   high while no load strobe has been seen for IDLE_CYCLES
// BEHAVIOUR
//  Reset values: joy_data=1, frame_done=0, overrun=0, link_idle=1.
//  Reset state: shift register all 1s, bit_cnt=0, idle counter=0.
//  Both strobes pass SYNC_STAGES flops, then one edge-detect register; all logic uses the synced versions.
//  Load (synced joy_load==0): shift register continuously reloaded with ~{joystick2,joystick1}.
//  During load, bit_cnt=0 and overrun is cleared.
//  Capture happens on the last clk_sys cycle of the low phase, so buttons are frozen at the load rising edge.
//  States: LOAD (joy_load low) -> SHIFT (joy_load high, bit_cnt<FRAME) -> DONE (bit_cnt==FRAME).
//  A falling edge of joy_load from any state returns to LOAD.
//  SHIFT: each synced joy_clk rising edge shifts the register right by one, with serial-in tied to 1.
//  SHIFT: each such edge also increments bit_cnt.
//  Output: joy_data = sr[0], registered.
//  Bit k (k=0 before any shift edge) = ~frame[k], where frame = {joystick2,joystick1}; player-1 bit 0 goes first.
//  Latency: joy_data settles SYNC_STAGES+2 clk_sys cycles after a joy_clk or joy_load edge (4 at default).
//  The receiver must sample no earlier than 100 ns after its own edge.
//  frame_done pulses on the edge that moves bit_cnt from FRAME-1 to FRAME.
//  DONE: further shift edges hold joy_data=1 and set overrun; bit_cnt saturates at FRAME.
//  joy_clk edge while joy_load low: ignored (register stays loaded) and does not count.
//  Edge of joy_clk coincident with joy_load rising (same synced cycle): the load wins and no shift occurs.
//  Pulses narrower than 2 clk_sys cycles on either strobe may be lost; this is not detected.
//  Idle counter: cleared on every synced load falling edge; saturates at IDLE_CYCLES.
//  link_idle = (counter==IDLE_CYCLES).
//  joystick1/2 are quasi-static and not synchronised; sampled only while in LOAD.
//  reset_n asserted mid-frame: immediate return to reset values.
//  After reset_n release, joy_data stays 1 until the first load.
// STRUCTURE
//  joy_db15_pkg: FRAME_BITS localparam, tx_state_t enum {LOAD,SHIFT,DONE}, bit_cnt width = $clog2(FRAME+1).
//  Sub-module joy_sync2: parameterised N-stage synchroniser with async active-low clear to 1.
//  Instanced twice: on joy_clk and joy_load.
//  Top holds the FSM, shift register, counters and output registers.
// TESTING
//  1 Bench: joystick1=16'h0001, joystick2=0; load pulse low 1 us, then 32 clocks at 1 MHz.
//    Required: bit0=0 and bits1..31=1 on joy_data; frame_done pulses once at edge 32.
//  2 Bench: joystick1=16'hA5C3, joystick2=16'h3C5A; real joy_db15 receiver looped back.
//    Required: receiver outputs equal the inputs after one frame.
//  3 Bench: 34 clock edges after one load.
//    Required: edges 33-34 give joy_data=1, overrun=1; the next load clears overrun to 0.
//  4 Bench: change joystick1 0000->FFFF during SHIFT.
//    Required: the frame in progress still reads all released; the next frame reads FFFF.
//  5 Bench: assert reset_n low after edge 10 of a frame.
//    Required: joy_data=1 and bit_cnt=0 immediately; the next full frame is correct.
//  6 Bench: no load for IDLE_CYCLES (shrunk to 1000 in sim).
//    Required: link_idle rises at cycle 1000; one load drops it within SYNC_STAGES+2 cycles.

Source files
------------

// File: rtl/joy_db15_tx_pkg.sv
// joy_db15_pkg: shared frame geometry and transmitter state encoding for the DB15 joystick responder.
package joy_db15_pkg;
    localparam int PLAYER_BITS_DEF = 16;
    localparam int FRAME_BITS = 2 * PLAYER_BITS_DEF;
    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);
    typedef enum logic [1:0] {LOAD, SHIFT, DONE} tx_state_t;
endpackage

// File: rtl/joy_db15_tx_if.sv
// joy_db15_tx_if: receiver-side strobes and button inputs toward the responder, serial data and status back.
interface joy_db15_tx_if #(parameter int PLAYER_BITS = 16);
    logic [PLAYER_BITS-1:0] joystick1;
    logic [PLAYER_BITS-1:0] joystick2;
    logic                   joy_load;
    logic                   joy_clk;
    logic                   joy_data;
    logic                   frame_done;
    logic                   overrun;
    logic                   link_idle;
    modport master (
        output joystick1, joystick2, joy_load, joy_clk,
        input  joy_data, frame_done, overrun, link_idle
    );
    modport slave (
        input  joystick1, joystick2, joy_load, joy_clk,
        output joy_data, frame_done, overrun, link_idle
    );
endinterface

// File: rtl/joy_db15_tx_sync2.sv
// joy_sync2: N-stage synchroniser, asynchronously cleared to 1 (strobes idle high).
module joy_sync2 #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [N-1:0] r_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[N-2:0], i_d};
    end
    assign o_q = r_sync[N-1];
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: DB15 joystick responder emulating the adapter's parallel-in/serial-out chain.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int PLAYER_BITS = PLAYER_BITS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 4800000
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    joy_db15_tx_if.slave  io_joy
);
    localparam int FRAME  = 2 * PLAYER_BITS;
    localparam int CNT_W  = $clog2(FRAME + 1);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

    logic              w_clk_s, w_load_s, w_clk_rise, w_load_fall;
    logic              r_clk_d, r_load_d;
    tx_state_t         r_state, w_state_nxt;
    logic              w_shift, w_extra, w_last;
    logic [FRAME-1:0]  r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_data, r_frame_done, r_overrun, r_boot;

    joy_sync2 #(.N(SYNC_STAGES)) u_sync_clk (
        .clk(clk_sys), .rst_n(reset_n), .i_d(io_joy.joy_clk), .o_q(w_clk_s)
    );
    joy_sync2 #(.N(SYNC_STAGES)) u_sync_load (
        .clk(clk_sys), .rst_n(reset_n), .i_d(io_joy.joy_load), .o_q(w_load_s)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_d  <= 1'b1;
            r_load_d <= 1'b1;
        end else begin
            r_clk_d  <= w_clk_s;
            r_load_d <= w_load_s;
        end
    end
    assign w_clk_rise  = w_clk_s & ~r_clk_d;
    assign w_load_fall = ~w_load_s & r_load_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= LOAD;
        else          r_state <= w_state_nxt;
    end

    // The first synced-high cycle is still LOAD, so a coincident shift edge is swallowed by the load.
    always_comb begin
        w_state_nxt = !w_load_s ? LOAD :
                      (r_state == LOAD) ? SHIFT :
                      w_last ? DONE : r_state;
    end

    always_comb begin
        w_shift = w_load_s && (r_state == SHIFT) && w_clk_rise;
        w_extra = w_load_s && (r_state == DONE) && w_clk_rise;
        w_last  = w_shift && (r_bit_cnt == CNT_W'(FRAME - 1));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sr         <= '1;
            r_bit_cnt    <= '0;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
            r_data       <= 1'b1;
        end else begin
            if (!w_load_s) begin
                r_sr      <= ~{io_joy.joystick2, io_joy.joystick1};
                r_bit_cnt <= '0;
                r_overrun <= 1'b0;
            end else if (w_shift) begin
                r_sr      <= {1'b1, r_sr[FRAME-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_extra) begin
                r_overrun <= 1'b1;
            end
            r_frame_done <= w_last;
            r_data       <= r_sr[0];
        end
    end

    // r_boot keeps the link reported idle from reset until the first load is ever seen.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
            r_boot     <= 1'b1;
        end else if (w_load_fall) begin
            r_idle_cnt <= '0;
            r_boot     <= 1'b0;
        end else if (r_idle_cnt != IDLE_W'(IDLE_CYCLES)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign io_joy.joy_data   = r_data;
    assign io_joy.frame_done = r_frame_done;
    assign io_joy.overrun    = r_overrun;
    assign io_joy.link_idle  = r_boot || (r_idle_cnt == IDLE_W'(IDLE_CYCLES));
endmodule
